// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one small FIFO per warp-in-slot, round-robin issue
// over non-empty queues, with a lock that holds an offered instruction until it is taken.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64,
  localparam int WIS_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [WIS_W-1:0]     wis_in,
  input  logic [DATAW-1:0]     data_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [WIS_W-1:0]     wis_out,
  output logic [DATAW-1:0]     data_out,
  output logic [NUM_WARPS-1:0] empty_mask,
  output logic [NUM_WARPS-1:0] full_mask
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [WIS_W:0] NW_EXT = (WIS_W + 1)'(NUM_WARPS);

  logic [NUM_WARPS-1:0][DATAW-1:0] head_data;
  logic [WIS_W-1:0] rr_ptr_reg;
  logic [WIS_W-1:0] lock_wis_reg;
  logic             lock_valid_reg;
  logic [WIS_W-1:0] sel_wis;
  logic             sel_found;
  logic             wis_in_ok;
  logic             push_fire;
  logic             pop_fire;
  logic [WIS_W:0]   cand_ext;
  logic [WIS_W:0]   rr_next_ext;

  // An out-of-range warp id (non power-of-two NUM_WARPS) is never accepted.
  assign wis_in_ok = ({1'b0, wis_in} < NW_EXT);
  assign ready_in  = wis_in_ok && !full_mask[wis_in];
  assign push_fire = valid_in && ready_in;
  assign pop_fire  = valid_out && ready_out;

  // Round-robin search upward from rr_ptr; a pending unaccepted offer overrides it.
  always_comb begin
    sel_found = 1'b0;
    sel_wis   = '0;
    cand_ext  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand_ext = {1'b0, rr_ptr_reg} + (WIS_W + 1)'(i);
      if (cand_ext >= NW_EXT) cand_ext = cand_ext - NW_EXT;
      if (!sel_found && !empty_mask[cand_ext[WIS_W-1:0]]) begin
        sel_found = 1'b1;
        sel_wis   = cand_ext[WIS_W-1:0];
      end
    end
    if (lock_valid_reg) sel_wis = lock_wis_reg;
  end

  assign valid_out = |(~empty_mask);
  assign wis_out   = sel_wis;
  assign data_out  = head_data[sel_wis];

  always_comb begin
    rr_next_ext = {1'b0, sel_wis} + (WIS_W + 1)'(1);
    if (rr_next_ext >= NW_EXT) rr_next_ext = rr_next_ext - NW_EXT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      lock_valid_reg <= 1'b0;
      lock_wis_reg   <= '0;
    end else if (pop_fire) begin
      rr_ptr_reg     <= rr_next_ext[WIS_W-1:0];
      lock_valid_reg <= 1'b0;
    end else if (valid_out) begin
      lock_valid_reg <= 1'b1;
      lock_wis_reg   <= sel_wis;
    end
  end

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic [DATAW-1:0] mem_reg [DEPTH];
    logic [PTRW-1:0]  rd_ptr_reg;
    logic [PTRW-1:0]  wr_ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic             push;
    logic             pop;

    assign push = push_fire && (wis_in == WIS_W'(gi));
    assign pop  = pop_fire && (sel_wis == WIS_W'(gi));

    always_ff @(posedge clk) begin
      if (push) mem_reg[wr_ptr_reg] <= data_in;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end

    assign empty_mask[gi] = (count_reg == '0);
    assign full_mask[gi]  = (count_reg == CNTW'(DEPTH));
    assign head_data[gi]  = mem_reg[rd_ptr_reg];

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) push |-> !full_mask[gi]);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) pop |-> !empty_mask[gi]);
    a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_reg <= CNTW'(DEPTH));
  end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Scoreboard bench for vx_warp_ibuffer: per-warp expected queues plus a round-robin/lock
// reference checked every cycle against all outputs.
module tb_vx_warp_ibuffer;
  localparam int NW = 4;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [1:0]  wis_in = '0;
  logic [63:0] data_in = '0;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic [1:0]  wis_out;
  logic [63:0] data_out;
  logic [3:0]  empty_mask;
  logic [3:0]  full_mask;

  vx_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DP), .DATAW(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .wis_in(wis_in), .data_in(data_in), .valid_out(valid_out), .ready_out(ready_out),
    .wis_out(wis_out), .data_out(data_out), .empty_mask(empty_mask), .full_mask(full_mask)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what each warp's queue holds, where the next search starts,
  // and which warp is being held because its offer was not taken.
  logic [63:0] mq [NW][$];
  int          rr = 0;
  bit          locked = 0;
  int          lock_w = 0;
  bit          checking = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    bit exp_valid;
    int sel, k;
    logic [3:0] exp_empty, exp_full;
    bit s_reset, s_vin, s_rdy;
    int s_win;
    logic [63:0] s_din;
    forever begin
      @(negedge clk);
      exp_valid = 0;
      sel = 0;
      if (locked) begin
        exp_valid = 1;
        sel = lock_w;
      end else begin
        for (int i = 0; i < NW; i++) begin
          k = (rr + i) % NW;
          if (!exp_valid && mq[k].size() > 0) begin
            exp_valid = 1;
            sel = k;
          end
        end
      end
      for (int w = 0; w < NW; w++) begin
        exp_empty[w] = (mq[w].size() == 0);
        exp_full[w]  = (mq[w].size() == DP);
      end
      if (checking) begin
        check("valid_out", 64'(valid_out), 64'(exp_valid));
        check("empty_mask", 64'(empty_mask), 64'(exp_empty));
        check("full_mask", 64'(full_mask), 64'(exp_full));
        check("ready_in", 64'(ready_in), 64'(!exp_full[wis_in]));
        if (exp_valid) begin
          check("wis_out", 64'(wis_out), 64'(sel));
          check("data_out", data_out, mq[sel][0]);
          $display("offer warp %0d data %h ready_out %0d", sel, mq[sel][0], ready_out);
        end
      end
      s_reset = reset; s_vin = valid_in; s_win = int'(wis_in); s_din = data_in; s_rdy = ready_out;
      @(posedge clk);
      if (s_reset) begin
        for (int w = 0; w < NW; w++) mq[w].delete();
        rr = 0;
        locked = 0;
        checking = 1;
      end else begin
        // Push acceptance depends on occupancy before any pop this cycle.
        bit do_push;
        do_push = s_vin && (mq[s_win].size() < DP);
        if (exp_valid && s_rdy) begin
          void'(mq[sel].pop_front());
          rr = (sel + 1) % NW;
          locked = 0;
        end else if (exp_valid) begin
          locked = 1;
          lock_w = sel;
        end
        if (do_push) mq[s_win].push_back(s_din);
      end
    end
  end

  task automatic step(input bit vi, input int w, input logic [63:0] d, input bit ro);
    valid_in = vi; wis_in = 2'(w); data_in = d; ready_out = ro;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    reset = 1'b1;
    repeat (2) step(0, 0, 0, 0);
    reset = 1'b0;
    // Single push, visible one cycle later.
    step(1, 2, 64'hA5, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    // Fill warp 0 and probe ready_in for warps 0 and 1.
    for (int i = 0; i < 4; i++) step(1, 0, 64'h100 + 64'(i), 0);
    step(1, 0, 64'hDEAD, 0);
    step(0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    // Round-robin across warps 0, 1, 3, then warp 0 again.
    step(1, 0, 64'h200, 0);
    step(1, 1, 64'h201, 0);
    step(1, 3, 64'h203, 0);
    repeat (3) step(0, 0, 0, 1);
    step(1, 0, 64'h204, 1);
    step(0, 0, 0, 1);
    // Hold warp 3 while warp 0 fills behind it.
    step(1, 3, 64'h300, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 64'h310 + 64'(i), 0);
    repeat (6) step(0, 0, 0, 1);
    // Full warp 1: pop plus refused push, then paired traffic across the wrap.
    for (int i = 0; i < 4; i++) step(1, 1, 64'h400 + 64'(i), 0);
    step(1, 1, 64'h4FF, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 64'h410 + 64'(i), 1);
    repeat (5) step(0, 0, 0, 1);
    // Reset with several queues occupied.
    step(1, 0, 64'h500, 0);
    step(1, 1, 64'h501, 0);
    step(1, 2, 64'h502, 0);
    reset = 1'b1;
    step(1, 3, 64'h503, 1);
    reset = 1'b0;
    step(0, 0, 0, 0);
    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      step(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
           {$urandom, $urandom}, bit'($urandom_range(0, 9) < 6));
    end
    reset = 1'b0;
    repeat (30) step(0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
